// File: rtl/soc_pkg.sv
// ============================================================================
// Module   : soc_pkg
// Brief    : Shared types for the RAM-port arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package soc_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_e;

    typedef enum logic [0:0] {
        ARB_M0 = 1'b0,
        ARB_M1 = 1'b1
    } arb_master_e;

endpackage

`default_nettype wire

// File: rtl/wb_ram_arb_watchdog.sv
// ============================================================================
// Module   : wb_ram_arb_watchdog
// Brief    : Counts unacknowledged grant cycles and flags expiry.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_ram_arb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_ni,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_disabled
            logic w_unused;
            assign w_unused = &{1'b0, clk, rst_ni, clear, enable};
            assign expire   = 1'b0;
        end else begin : g_enabled
            localparam int                C_CNT_W = $clog2(TIMEOUT_CYCLES);
            localparam logic [C_CNT_W-1:0] C_LAST = C_CNT_W'(TIMEOUT_CYCLES - 1);

            logic [C_CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_cnt <= '0;
                end else if (clear) begin
                    r_cnt <= '0;
                end else if (enable) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            // Expiry is only meaningful while counting; the FSM leaves GRANT on it.
            assign expire = enable && (r_cnt == C_LAST);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/wb_ram_arbiter.sv
// ============================================================================
// Module   : wb_ram_arbiter
// Brief    : Round-robin two-master Wishbone arbiter with gap cycle and watchdog.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_ram_arbiter
    import soc_pkg::*;
#(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     wb_clk_i,
    input  logic                     rst_ni,

    input  logic                     m0_cyc_i,
    input  logic                     m0_stb_i,
    input  logic                     m0_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [31:0]              m0_wdata_i,
    output logic [31:0]              m0_rdata_o,
    output logic                     m0_ack_o,
    output logic                     m0_err_o,

    input  logic                     m1_cyc_i,
    input  logic                     m1_stb_i,
    input  logic                     m1_we_i,
    input  logic [WB_ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [31:0]              m1_wdata_i,
    output logic [31:0]              m1_rdata_o,
    output logic                     m1_ack_o,
    output logic                     m1_err_o,

    output logic                     s_cyc_o,
    output logic                     s_stb_o,
    output logic                     s_we_o,
    output logic [WB_ADDR_WIDTH-1:0] s_addr_o,
    output logic [31:0]              s_wdata_o,
    input  logic [31:0]              s_rdata_i,
    input  logic                     s_ack_i,

    output logic [1:0]               grant_o,
    output logic                     timeout_o
);

    arb_state_e  r_state, w_state_nxt;
    arb_master_e r_owner, w_owner_nxt;
    arb_master_e r_last,  w_last_nxt;

    logic w_req0, w_req1, w_in_grant, w_own_cyc, w_expire;

    assign w_req0     = m0_cyc_i & m0_stb_i;
    assign w_req1     = m1_cyc_i & m1_stb_i;
    assign w_in_grant = (r_state == ARB_GRANT);
    assign w_own_cyc  = (r_owner == ARB_M0) ? m0_cyc_i : m1_cyc_i;

    wb_ram_arb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (wb_clk_i),
        .rst_ni (rst_ni),
        .clear  (!w_in_grant),
        .enable (w_in_grant & ~s_ack_i),
        .expire (w_expire)
    );

    always_ff @(posedge wb_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ARB_IDLE;
            r_owner <= ARB_M0;
            r_last  <= ARB_M1;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        case (r_state)
            ARB_IDLE: begin
                if (w_req0 && w_req1) begin
                    // Contention goes to whoever was not served last.
                    w_owner_nxt = (r_last == ARB_M0) ? ARB_M1 : ARB_M0;
                    w_state_nxt = ARB_GRANT;
                end else if (w_req0) begin
                    w_owner_nxt = ARB_M0;
                    w_state_nxt = ARB_GRANT;
                end else if (w_req1) begin
                    w_owner_nxt = ARB_M1;
                    w_state_nxt = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                if (s_ack_i || !w_own_cyc || w_expire) begin
                    w_last_nxt  = r_owner;
                    w_state_nxt = ARB_GAP;
                end
            end
            ARB_GAP:  w_state_nxt = ARB_IDLE;
            default:  w_state_nxt = ARB_IDLE;
        endcase
    end

    always_comb begin
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_addr_o   = '0;
        s_wdata_o  = '0;
        m0_rdata_o = '0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m1_rdata_o = '0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        if (w_in_grant) begin
            s_cyc_o = 1'b1;
            s_stb_o = 1'b1;
            if (r_owner == ARB_M0) begin
                s_we_o     = m0_we_i;
                s_addr_o   = m0_addr_i;
                s_wdata_o  = m0_wdata_i;
                m0_rdata_o = s_rdata_i;
                m0_ack_o   = s_ack_i;
                m0_err_o   = w_expire;
            end else begin
                s_we_o     = m1_we_i;
                s_addr_o   = m1_addr_i;
                s_wdata_o  = m1_wdata_i;
                m1_rdata_o = s_rdata_i;
                m1_ack_o   = s_ack_i;
                m1_err_o   = w_expire;
            end
        end
    end

    assign grant_o   = w_in_grant ? ((r_owner == ARB_M0) ? 2'b01 : 2'b10) : 2'b00;
    assign timeout_o = w_expire;

endmodule

`default_nettype wire
